l2_prefetch_fill: RTL and testbench

- Write-side companion to the L2 prefetch buffer: on a prefetch miss, fetches one cache line from the host bus and writes it into the buffer's WRA/WRD/WR/WRM/CLR port.
- Fetch order is critical-word-first with wrap-around inside the line.
- Snoops FSB writes and invalidates the buffer (CLR) when a write hits the line being filled or the last line filled.
- Sits between the chip-select/size-decode logic and L2Prefetch, in the FSBCLK domain.

---
 rtl/l2_pkg.sv | 21 ++
 rtl/l2_fill_timeout.sv | 31 +++
 rtl/l2_prefetch_fill.sv | 184 ++++++++++++++++++
 tb/tb_l2_prefetch_fill.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared types and constants for the L2 prefetch fill engine
package l2_pkg;

  // Host word addresses are byte address bits [27:2]
  localparam int ADDR_W = 26;

  // Byte mask for a full 32-bit word write into the prefetch buffer
  localparam logic [3:0] WRM_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  // Word-index width for a line of 'words' words (words is a power of 2)
  function automatic int line_iw(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/l2_fill_timeout.sv
// rtl/l2_fill_timeout.sv - loadable down-counter with clear and expire flag
module l2_fill_timeout #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Clear has priority over load; counting stops at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/l2_prefetch_fill.sv
// rtl/l2_prefetch_fill.sv - critical-word-first line fill into the L2 prefetch buffer
module l2_prefetch_fill
  import l2_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MissValid,
  input  logic [ADDR_W-1:0] MissA,
  output logic              MissReady,
  output logic              BusReq,
  output logic [ADDR_W-1:0] BusA,
  input  logic              BusAck,
  input  logic [31:0]       BusD,
  input  logic              BusErr,
  input  logic              SnoopWR,
  input  logic [ADDR_W-1:0] SnoopA,
  output logic [ADDR_W-1:0] WRA,
  output logic [31:0]       WRD,
  output logic              WR,
  output logic [3:0]        WRM,
  output logic              CLR,
  output logic              Done,
  output logic              Err
);

  localparam int IW = line_iw(LINE_WORDS);
  localparam int TW = ADDR_W - IW;
  localparam logic [IW:0] LAST_CNT = (IW+1)'(LINE_WORDS - 1);
  // Loaded with TIMEOUT-1 so the abort fires on the TIMEOUT-th waiting cycle
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

  fill_state_t r_state, w_state_nxt;

  logic [TW-1:0]     r_tag, r_last_tag;
  logic [IW-1:0]     r_idx;
  logic [IW:0]       r_cnt;
  logic              r_busreq, r_wr, r_clr, r_done, r_err;
  logic              r_last_valid, r_dirty;
  logic [ADDR_W-1:0] r_wra;
  logic [31:0]       r_wrd;

  logic w_accept, w_ack, w_abort, w_done_clean, w_done_dirty, w_idle_clr;
  logic w_busreq_nxt, w_dirty_set, w_expired, w_tmr_load;
  logic w_fill_hit, w_last_hit;
  logic w_unused_snoop_lo;

  assign w_fill_hit = SnoopWR && (SnoopA[ADDR_W-1:IW] == r_tag);
  assign w_last_hit = SnoopWR && r_last_valid && (SnoopA[ADDR_W-1:IW] == r_last_tag);
  assign w_unused_snoop_lo = ^SnoopA[IW-1:0];

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control decode
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_ack        = 1'b0;
    w_abort      = 1'b0;
    w_done_clean = 1'b0;
    w_done_dirty = 1'b0;
    w_idle_clr   = 1'b0;
    w_busreq_nxt = 1'b0;
    w_dirty_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle_clr = w_last_hit;
        if (MissValid) begin
          w_accept     = 1'b1;
          w_busreq_nxt = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        w_dirty_set = w_fill_hit;
        if (!r_busreq) begin
          // One idle cycle after each ack, then request the next word
          w_busreq_nxt = 1'b1;
        end else if (BusErr || (!BusAck && w_expired)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (BusAck) begin
          w_ack = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_busreq_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (r_dirty || w_fill_hit) begin
          w_done_dirty = 1'b1;
        end else begin
          w_done_clean = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_tmr_load = w_accept || w_ack || ((r_state == ST_REQ) && !r_busreq);

  l2_fill_timeout #(
    .W (16)
  ) u_timeout (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clr      (w_abort),
    .i_load     (w_tmr_load),
    .i_load_val (TMO_LOAD),
    .i_en       (r_busreq),
    .o_expired  (w_expired)
  );

  // Fill datapath, buffer write port and status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_busreq     <= 1'b0;
      r_wra        <= '0;
      r_wrd        <= '0;
      r_wr         <= 1'b0;
      r_clr        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_last_valid <= 1'b0;
      r_last_tag   <= '0;
      r_dirty      <= 1'b0;
    end else begin
      r_busreq <= w_busreq_nxt;
      r_wr     <= w_ack;
      r_clr    <= w_abort || w_done_dirty || w_idle_clr;
      r_done   <= w_done_clean;
      r_err    <= w_abort;
      if (w_accept) begin
        {r_tag, r_idx} <= MissA;
        r_cnt          <= '0;
      end else if (w_ack) begin
        r_wra <= {r_tag, r_idx};
        r_wrd <= BusD;
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_dirty <= 1'b0;
      end else if (w_dirty_set) begin
        r_dirty <= 1'b1;
      end
      if (w_abort || w_done_dirty || w_idle_clr) begin
        r_last_valid <= 1'b0;
      end else if (w_done_clean) begin
        r_last_valid <= 1'b1;
        r_last_tag   <= r_tag;
      end
    end
  end

  assign MissReady = (r_state == ST_IDLE);
  assign BusReq    = r_busreq;
  assign BusA      = {r_tag, r_idx};
  assign WRA       = r_wra;
  assign WRD       = r_wrd;
  assign WR        = r_wr;
  assign WRM       = r_wr ? WRM_FULL : 4'h0;
  assign CLR       = r_clr;
  assign Done      = r_done;
  assign Err       = r_err;

endmodule

// File: tb/tb_l2_prefetch_fill.sv
// tb/tb_l2_prefetch_fill.sv - directed self-checking bench for l2_prefetch_fill
module tb_l2_prefetch_fill;

  logic        CLK, RST, MissValid, MissReady, BusReq, BusAck, BusErr, SnoopWR;
  logic        WR, CLR, Done, Err;
  logic [25:0] MissA, BusA, SnoopA, WRA;
  logic [31:0] BusD, WRD;
  logic [3:0]  WRM;

  l2_prefetch_fill #(.LINE_WORDS(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .MissValid(MissValid), .MissA(MissA), .MissReady(MissReady),
    .BusReq(BusReq), .BusA(BusA), .BusAck(BusAck), .BusD(BusD), .BusErr(BusErr),
    .SnoopWR(SnoopWR), .SnoopA(SnoopA), .WRA(WRA), .WRD(WRD), .WR(WR), .WRM(WRM),
    .CLR(CLR), .Done(Done), .Err(Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus responder: 0 = ack on 2nd request cycle, 1 = error on request err_word, 2 = silent
  int resp_mode = 0;
  int err_word  = -1;
  int wait_cnt  = 0;
  int req_num   = 0;

  // Event log gathered at the falling edge
  logic [25:0] busa_log[16];
  logic [25:0] wra_log[16];
  logic [31:0] wrd_log[16];
  int nbus, nwr, ndone, nerr, nclr, nerrclr, nreqcyc, nbad;
  logic busreq_prev = 1'b0;
  logic seen_busy   = 1'b0;

  function automatic logic [31:0] data_of(input logic [25:0] a);
    return {6'h15, a};
  endfunction

  always @(negedge CLK) begin
    BusAck = 1'b0;
    BusErr = 1'b0;
    if (BusReq && resp_mode != 2) begin
      wait_cnt++;
      if (wait_cnt == 2) begin
        if (resp_mode == 1 && req_num == err_word) BusErr = 1'b1;
        else begin
          BusAck = 1'b1;
          BusD   = data_of(BusA);
        end
        wait_cnt = 0;
        req_num++;
      end
    end else if (!BusReq) begin
      wait_cnt = 0;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (BusReq && !busreq_prev && nbus < 16) begin
        busa_log[nbus] = BusA;
        nbus++;
      end
      busreq_prev = BusReq;
      if (BusReq) nreqcyc++;
      if (!MissReady) seen_busy = 1'b1;
      if (WR) begin
        if (nwr < 16) begin
          wra_log[nwr] = WRA;
          wrd_log[nwr] = WRD;
        end
        nwr++;
        if (WRM != 4'hF) nbad++;
      end else if (WRM != 4'h0) nbad++;
      if (Done) ndone++;
      if (Err) nerr++;
      if (CLR) nclr++;
      if (Err && CLR) nerrclr++;
      if (Done && Err) nbad++;
    end
  end

  task automatic clear_log();
    nbus = 0; nwr = 0; ndone = 0; nerr = 0; nclr = 0; nerrclr = 0; nreqcyc = 0;
    wait_cnt = 0; req_num = 0; seen_busy = 1'b0;
  endtask

  task automatic do_miss(input logic [25:0] a);
    @(negedge CLK);
    MissValid = 1'b1;
    MissA     = a;
    @(negedge CLK);
    MissValid = 1'b0;
  endtask

  // Wait until the engine has gone busy and returned to idle, plus a margin
  task automatic wait_end(input string tag);
    bit ended = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      if (seen_busy && MissReady) begin
        ended = 1;
        break;
      end
    end
    repeat (3) @(negedge CLK);
    chk({tag, "_end"}, 32'(ended), 32'd1);
  endtask

  task automatic chk_fill(input string t, input logic [25:0] a0, a1, a2, a3);
    logic [25:0] e[4];
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    chk({t, "_nbus"}, nbus, 4);
    chk({t, "_nwr"}, nwr, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_busa%0d", t, i), busa_log[i], e[i]);
      chk($sformatf("%s_wra%0d", t, i), wra_log[i], e[i]);
      chk($sformatf("%s_wrd%0d", t, i), wrd_log[i], data_of(e[i]));
    end
  endtask

  task automatic snoop(input logic [25:0] a);
    @(negedge CLK);
    SnoopWR = 1'b1;
    SnoopA  = a;
    @(negedge CLK);
    SnoopWR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; MissValid = 1'b0; MissA = '0; BusAck = 1'b0; BusErr = 1'b0;
    BusD = '0; SnoopWR = 1'b0; SnoopA = '0;
    nbad = 0;
    clear_log();
    #12;
    chk("rst_ready", 32'(MissReady), 32'd1);
    chk("rst_pulses", 32'({BusReq, WR, WRM, CLR, Done, Err}), 32'd0);
    chk("rst_busa", 32'(BusA), 32'd0);
    chk("rst_wra", 32'(WRA), 32'd0);
    chk("rst_wrd", WRD, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Aligned fill
    clear_log();
    do_miss(26'h0000100);
    wait_end("aligned");
    chk_fill("aligned", 26'h100, 26'h101, 26'h102, 26'h103);
    chk("aligned_done", ndone, 1);
    chk("aligned_clr", nclr, 0);
    chk("aligned_ready", 32'(MissReady), 32'd1);

    // Critical-word-first wrap
    clear_log();
    do_miss(26'h0000106);
    wait_end("wrap");
    chk_fill("wrap", 26'h106, 26'h107, 26'h104, 26'h105);
    chk("wrap_done", ndone, 1);

    // Bus error on the third word
    clear_log();
    resp_mode = 1; err_word = 2;
    do_miss(26'h0000300);
    wait_end("buserr");
    repeat (4) @(negedge CLK);
    chk("buserr_nwr", nwr, 2);
    chk("buserr_err", nerr, 1);
    chk("buserr_errclr", nerrclr, 1);
    chk("buserr_done", ndone, 0);
    chk("buserr_nbus", nbus, 3);

    // Timeout with no acknowledge
    clear_log();
    resp_mode = 2;
    do_miss(26'h0000400);
    wait_end("tmo");
    chk("tmo_reqcyc", nreqcyc, 8);
    chk("tmo_errclr", nerrclr, 1);
    chk("tmo_busreq", 32'(BusReq), 32'd0);
    chk("tmo_idle", 32'(MissReady), 32'd1);
    chk("tmo_nwr", nwr, 0);

    // Snoop hit during the fill
    clear_log();
    resp_mode = 0; err_word = -1;
    do_miss(26'h0000100);
    repeat (2) @(negedge CLK);
    snoop(26'h0000102);
    wait_end("sfill");
    chk("sfill_nwr", nwr, 4);
    chk("sfill_clr", nclr, 1);
    chk("sfill_done", ndone, 0);
    clear_log();
    snoop(26'h0000101);
    chk("sfill_nolast", 32'(CLR), 32'd0);

    // Snoops in idle after a clean fill
    clear_log();
    do_miss(26'h0000100);
    wait_end("clean");
    chk("clean_done", ndone, 1);
    snoop(26'h0000200);
    chk("smiss_clr", 32'(CLR), 32'd0);
    snoop(26'h0000101);
    chk("shit_clr", 32'(CLR), 32'd1);
    @(negedge CLK);
    chk("shit_clr_once", 32'(CLR), 32'd0);

    // Miss accepted in the same cycle as an idle snoop hit
    clear_log();
    do_miss(26'h0000100);
    wait_end("pre");
    clear_log();
    @(negedge CLK);
    MissValid = 1'b1; MissA = 26'h0000104; SnoopWR = 1'b1; SnoopA = 26'h0000103;
    @(negedge CLK);
    MissValid = 1'b0; SnoopWR = 1'b0;
    chk("both_clr", 32'(CLR), 32'd1);
    wait_end("both");
    chk("both_done", ndone, 1);
    chk("both_nbus", nbus, 4);

    // Reset in the middle of a fill
    clear_log();
    do_miss(26'h0000100);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      #1;
      if (nwr >= 2) break;
    end
    chk("rmid_two_wr", nwr, 2);
    resp_mode = 2;
    #1;
    RST = 1'b1;
    #1;
    chk("rmid_pulses", 32'({BusReq, WR, WRM, CLR, Done, Err}), 32'd0);
    chk("rmid_ready", 32'(MissReady), 32'd1);
    chk("rmid_addr", 32'({BusA, WRA} != 52'd0), 32'd0);
    chk("rmid_wrd", WRD, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clear_log();
    repeat (5) @(negedge CLK);
    chk("rmid_quiet", nwr + nclr + ndone + nerr + nbus, 0);
    resp_mode = 0;
    do_miss(26'h0000104);
    wait_end("rnew");
    chk_fill("rnew", 26'h104, 26'h105, 26'h106, 26'h107);
    chk("rnew_done", ndone, 1);

    chk("pulse_rules", nbad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
